// File: rtl/hazard_controller.sv
// hazard_controller: pipeline sequencing for the 5-stage RV32 core.
// A 3-entry destination scoreboard (EX, MEM, WB) detects RAW hazards because
// the datapath has no forwarding. Each cycle one action is chosen by
// priority: FREEZE (data memory busy) > FLUSH (EX redirect) > DSTALL
// (hazard on a valid ID instruction) > RUN.
//
// The control outputs are combinational and valid in the same cycle as the
// inputs. The chosen action is registered into cause and drives two
// saturating performance counters.
module hazard_controller #(
  parameter bit WB_BYPASS = 1'b0,
  parameter int CW        = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [4:0]    id_rs1,
  input  logic [4:0]    id_rs2,
  input  logic          id_use_rs1,
  input  logic          id_use_rs2,
  input  logic [4:0]    id_rd,
  input  logic          id_regwrite,
  input  logic          ex_redirect,
  input  logic          mem_busy,
  input  logic          perf_clr,
  output logic          stall_pc,
  output logic          stall_ifid,
  output logic          flush_ifid,
  output logic          bubble_idex,
  output logic          freeze_all,
  output logic [1:0]    cause,
  output logic [CW-1:0] stall_cnt,
  output logic [CW-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    ACT_RUN    = 2'd0,
    ACT_DSTALL = 2'd1,
    ACT_FREEZE = 2'd2,
    ACT_FLUSH  = 2'd3
  } action_t;

  // Scoreboard entries: valid bit plus destination register.
  logic       sb_ex_v, sb_mem_v, sb_wb_v;
  logic [4:0] sb_ex_rd, sb_mem_rd, sb_wb_rd;

  logic    hit_rs1;
  logic    hit_rs2;
  logic    hazard;
  logic    rec_v;
  action_t action;

  // Source match against in-flight writers; x0 never matches, and the WB
  // entry is ignored when the register file writes through.
  always_comb begin
    hit_rs1 = 1'b0;
    hit_rs2 = 1'b0;
    if (id_use_rs1 && (id_rs1 != 5'd0)) begin
      hit_rs1 = (sb_ex_v  && (sb_ex_rd  == id_rs1)) ||
                (sb_mem_v && (sb_mem_rd == id_rs1)) ||
                (!WB_BYPASS && sb_wb_v && (sb_wb_rd == id_rs1));
    end
    if (id_use_rs2 && (id_rs2 != 5'd0)) begin
      hit_rs2 = (sb_ex_v  && (sb_ex_rd  == id_rs2)) ||
                (sb_mem_v && (sb_mem_rd == id_rs2)) ||
                (!WB_BYPASS && sb_wb_v && (sb_wb_rd == id_rs2));
    end
    hazard = id_valid && (hit_rs1 || hit_rs2);
    // x0 writes are never recorded.
    rec_v  = id_valid && id_regwrite && (id_rd != 5'd0);
  end

  // Priority selection of this cycle's action. The inputs still act during
  // reset, where the scoreboard is already empty so no hazard can appear.
  always_comb begin
    action = ACT_RUN;
    if (mem_busy) begin
      action = ACT_FREEZE;
    end else if (ex_redirect) begin
      action = ACT_FLUSH;
    end else if (hazard) begin
      action = ACT_DSTALL;
    end
  end

  // Decode the action into the pipeline register controls.
  always_comb begin
    stall_pc    = 1'b0;
    stall_ifid  = 1'b0;
    flush_ifid  = 1'b0;
    bubble_idex = 1'b0;
    freeze_all  = 1'b0;
    case (action)
      ACT_FREEZE: begin
        stall_pc   = 1'b1;
        stall_ifid = 1'b1;
        freeze_all = 1'b1;
      end
      ACT_FLUSH: begin
        flush_ifid  = 1'b1;
        bubble_idex = 1'b1;
      end
      ACT_DSTALL: begin
        stall_pc    = 1'b1;
        stall_ifid  = 1'b1;
        bubble_idex = 1'b1;
      end
      default: ;
    endcase
  end

  // Scoreboard advance. It holds on freeze. On flush or stall it shifts with
  // a bubble entering EX, so killed or held instructions are never recorded.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_ex_v   <= 1'b0;
      sb_mem_v  <= 1'b0;
      sb_wb_v   <= 1'b0;
      sb_ex_rd  <= 5'd0;
      sb_mem_rd <= 5'd0;
      sb_wb_rd  <= 5'd0;
    end else if (action != ACT_FREEZE) begin
      sb_wb_v   <= sb_mem_v;
      sb_wb_rd  <= sb_mem_rd;
      sb_mem_v  <= sb_ex_v;
      sb_mem_rd <= sb_ex_rd;
      if (action == ACT_RUN) begin
        sb_ex_v  <= rec_v;
        sb_ex_rd <= id_rd;
      end else begin
        sb_ex_v  <= 1'b0;
        sb_ex_rd <= 5'd0;
      end
    end
  end

  // Registered cause of the previous cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cause <= ACT_RUN;
    end else begin
      cause <= action;
    end
  end

  // Saturating stall and flush counters. A clear request wins over a
  // simultaneous increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (perf_clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if ((action == ACT_DSTALL) && (stall_cnt != {CW{1'b1}})) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if ((action == ACT_FLUSH) && (flush_cnt != {CW{1'b1}})) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller. Three instances share one stimulus stream:
// dut0 has WB_BYPASS=0 and CW=16, dut1 has WB_BYPASS=1 and CW=16, and dut2
// has WB_BYPASS=0 and CW=4.
// A behavioural model tracks the destination registers of the three
// instructions ahead of ID as a list. It is compared against every instance
// on each falling clock edge. Directed scenarios add hand-computed checks.
module tb_hazard_controller;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       id_valid = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic       id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, id_regwrite = 1'b0;
  logic       ex_redirect = 1'b0, mem_busy = 1'b0, perf_clr = 1'b0;

  logic       stall_pc_w[3], stall_ifid_w[3], flush_ifid_w[3];
  logic       bubble_idex_w[3], freeze_all_w[3];
  logic [1:0] cause_w[3];
  logic [15:0] sc0, sc1, fc0, fc1;
  logic [3:0]  sc2, fc2;

  hazard_controller #(.WB_BYPASS(1'b0), .CW(16)) dut0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .ex_redirect(ex_redirect), .mem_busy(mem_busy),
    .perf_clr(perf_clr), .stall_pc(stall_pc_w[0]), .stall_ifid(stall_ifid_w[0]),
    .flush_ifid(flush_ifid_w[0]), .bubble_idex(bubble_idex_w[0]),
    .freeze_all(freeze_all_w[0]), .cause(cause_w[0]), .stall_cnt(sc0), .flush_cnt(fc0));

  hazard_controller #(.WB_BYPASS(1'b1), .CW(16)) dut1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .ex_redirect(ex_redirect), .mem_busy(mem_busy),
    .perf_clr(perf_clr), .stall_pc(stall_pc_w[1]), .stall_ifid(stall_ifid_w[1]),
    .flush_ifid(flush_ifid_w[1]), .bubble_idex(bubble_idex_w[1]),
    .freeze_all(freeze_all_w[1]), .cause(cause_w[1]), .stall_cnt(sc1), .flush_cnt(fc1));

  hazard_controller #(.WB_BYPASS(1'b0), .CW(4)) dut2 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .ex_redirect(ex_redirect), .mem_busy(mem_busy),
    .perf_clr(perf_clr), .stall_pc(stall_pc_w[2]), .stall_ifid(stall_ifid_w[2]),
    .flush_ifid(flush_ifid_w[2]), .bubble_idex(bubble_idex_w[2]),
    .freeze_all(freeze_all_w[2]), .cause(cause_w[2]), .stall_cnt(sc2), .flush_cnt(fc2));

  // ---------------- scoreboard counters ----------------
  int compares = 0;
  int errors   = 0;

  task automatic chk(input string nm, input int k, input int act, input int exp);
    compares++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut%0d @%0t: got %0d expected %0d", nm, k, $time, act, exp);
    end
  endtask

  function automatic int get_sc(input int k);
    if (k == 0) return int'(sc0);
    if (k == 1) return int'(sc1);
    return int'(sc2);
  endfunction

  function automatic int get_fc(input int k);
    if (k == 0) return int'(fc0);
    if (k == 1) return int'(fc1);
    return int'(fc2);
  endfunction

  // ---------------- behavioural model ----------------
  // m_dst[k][0..2]: destination of the instruction in EX, MEM, WB (0 = none).
  int m_dst[3][3];
  int m_cause[3];
  int m_sc[3];
  int m_fc[3];
  bit bypass[3] = '{1'b0, 1'b1, 1'b0};
  int cmax[3]   = '{65535, 65535, 15};

  function automatic bit reads_pending(input int k, input bit used, input int src);
    if (!used || src == 0) return 1'b0;
    if (m_dst[k][0] == src || m_dst[k][1] == src) return 1'b1;
    if (!bypass[k] && m_dst[k][2] == src) return 1'b1;
    return 1'b0;
  endfunction

  // Compare every instance against the model, then advance the model to
  // the state that the next rising edge produces.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      int  act;
      bit  hz;
      if (!rst) begin
        for (int j = 0; j < 3; j++) m_dst[k][j] = 0;
        m_cause[k] = 0;
        m_sc[k]    = 0;
        m_fc[k]    = 0;
      end
      hz = id_valid && (reads_pending(k, id_use_rs1, int'(id_rs1)) ||
                        reads_pending(k, id_use_rs2, int'(id_rs2)));
      if (mem_busy)         act = 2;
      else if (ex_redirect) act = 3;
      else if (hz)          act = 1;
      else                  act = 0;

      chk("stall_pc",    k, int'(stall_pc_w[k]),    int'(act == 1 || act == 2));
      chk("stall_ifid",  k, int'(stall_ifid_w[k]),  int'(act == 1 || act == 2));
      chk("flush_ifid",  k, int'(flush_ifid_w[k]),  int'(act == 3));
      chk("bubble_idex", k, int'(bubble_idex_w[k]), int'(act == 1 || act == 3));
      chk("freeze_all",  k, int'(freeze_all_w[k]),  int'(act == 2));
      chk("cause",       k, int'(cause_w[k]),       m_cause[k]);
      chk("stall_cnt",   k, get_sc(k),              m_sc[k]);
      chk("flush_cnt",   k, get_fc(k),              m_fc[k]);

      if (rst) begin
        if (act != 2) begin
          m_dst[k][2] = m_dst[k][1];
          m_dst[k][1] = m_dst[k][0];
          m_dst[k][0] = (act == 0 && id_valid && id_regwrite) ? int'(id_rd) : 0;
        end
        m_cause[k] = act;
        if (perf_clr) begin
          m_sc[k] = 0;
          m_fc[k] = 0;
        end else begin
          if (act == 1 && m_sc[k] < cmax[k]) m_sc[k]++;
          if (act == 3 && m_fc[k] < cmax[k]) m_fc[k]++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input int rs1, input bit u1, input int rs2,
                       input bit u2, input int rd, input bit rw,
                       input bit redir, input bit busy, input bit clr);
    id_valid    = v;
    id_rs1      = rs1[4:0];
    id_use_rs1  = u1;
    id_rs2      = rs2[4:0];
    id_use_rs2  = u2;
    id_rd       = rd[4:0];
    id_regwrite = rw;
    ex_redirect = redir;
    mem_busy    = busy;
    perf_clr    = clr;
  endtask

  task automatic instr(input int rs1, input bit u1, input int rs2, input bit u2,
                       input int rd, input bit rw);
    drive(1'b1, rs1, u1, rs2, u2, rd, rw, 1'b0, 1'b0, 1'b0);
    step();
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
    end
  endtask

  task automatic clear_cnt();
    drive(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    #1 rst = 1'b0;
    // Reset and idle.
    nops(3);
    for (int k = 0; k < 3; k++) begin
      chk("rst_ctl",   k, int'(stall_pc_w[k] | flush_ifid_w[k] | freeze_all_w[k] | bubble_idex_w[k]), 0);
      chk("rst_cause", k, int'(cause_w[k]), 0);
      chk("rst_scnt",  k, get_sc(k), 0);
    end
    rst = 1'b1;
    for (int i = 0; i < 6; i++) instr(1, 1'b1, 2, 1'b1, 10 + i, 1'b1);
    nops(3);
    for (int k = 0; k < 3; k++) chk("indep_scnt", k, get_sc(k), 0);

    // RAW: lw x5 then add x6,x5,x1 held in ID.
    clear_cnt();
    instr(1, 1'b1, 0, 1'b0, 5, 1'b1);
    for (int i = 0; i < 4; i++) instr(5, 1'b1, 1, 1'b1, 6, 1'b1);
    nops(3);
    chk("raw_scnt", 0, get_sc(0), 3);
    chk("raw_scnt", 1, get_sc(1), 2);
    chk("raw_scnt", 2, get_sc(2), 3);

    // x0 and unused sources.
    clear_cnt();
    instr(0, 1'b1, 0, 1'b0, 0, 1'b1);
    instr(0, 1'b1, 0, 1'b1, 7, 1'b1);
    instr(1, 1'b1, 0, 1'b0, 3, 1'b1);
    instr(1, 1'b1, 3, 1'b0, 8, 1'b1);
    nops(3);
    for (int k = 0; k < 3; k++) chk("x0_scnt", k, get_sc(k), 0);

    // Redirect in the first stall cycle.
    clear_cnt();
    instr(1, 1'b1, 0, 1'b0, 5, 1'b1);
    drive(1'b1, 5, 1'b1, 1, 1'b1, 6, 1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    chk("redir_flush",  0, int'(flush_ifid_w[0]), 1);
    chk("redir_bubble", 0, int'(bubble_idex_w[0]), 1);
    chk("redir_stall",  0, int'(stall_pc_w[0]), 0);
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) chk("redir_cause", k, int'(cause_w[k]), 3);
    instr(6, 1'b1, 0, 1'b0, 9, 1'b1);
    nops(3);
    for (int k = 0; k < 3; k++) begin
      chk("redir_fcnt", k, get_fc(k), 1);
      chk("redir_scnt", k, get_sc(k), 0);
    end

    // Freeze with producer in EX and consumer in ID.
    clear_cnt();
    instr(1, 1'b1, 0, 1'b0, 5, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5, 1'b1, 1, 1'b1, 6, 1'b1, 1'b0, 1'b1, 1'b0);
      #1;
      chk("frz_freeze_all", 0, int'(freeze_all_w[0]), 1);
      chk("frz_bubble",     0, int'(bubble_idex_w[0]), 0);
      @(posedge clk); #1;
    end
    for (int k = 0; k < 3; k++) chk("frz_scnt_hold", k, get_sc(k), 0);
    for (int i = 0; i < 4; i++) instr(5, 1'b1, 1, 1'b1, 6, 1'b1);
    nops(3);
    chk("frz_scnt", 0, get_sc(0), 3);
    chk("frz_scnt", 1, get_sc(1), 2);

    // Saturation: 7 RAW pairs give 21 stall cycles on the bypass-less parts.
    clear_cnt();
    for (int p = 0; p < 7; p++) begin
      instr(1, 1'b1, 0, 1'b0, 5, 1'b1);
      for (int i = 0; i < 4; i++) instr(5, 1'b1, 1, 1'b1, 6, 1'b1);
    end
    nops(3);
    chk("sat_scnt", 0, get_sc(0), 21);
    chk("sat_scnt", 1, get_sc(1), 14);
    chk("sat_scnt", 2, get_sc(2), 15);

    // perf_clr coinciding with a stall cycle.
    instr(1, 1'b1, 0, 1'b0, 5, 1'b1);
    drive(1'b1, 5, 1'b1, 1, 1'b1, 6, 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    for (int k = 0; k < 3; k++) chk("clr_scnt", k, get_sc(k), 0);
    for (int i = 0; i < 3; i++) instr(5, 1'b1, 1, 1'b1, 6, 1'b1);
    nops(3);
    chk("clr_after", 0, get_sc(0), 2);
    chk("clr_after", 1, get_sc(1), 1);

    // Mid-stall reset empties the scoreboard.
    instr(1, 1'b1, 0, 1'b0, 5, 1'b1);
    instr(5, 1'b1, 1, 1'b1, 6, 1'b1);
    rst = 1'b0;
    #1;
    chk("rststall_ctl", 0, int'(stall_pc_w[0]), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    instr(5, 1'b1, 1, 1'b1, 6, 1'b1);
    chk("rststall_cause", 0, int'(cause_w[0]), 0);

    // Random traffic with small register numbers to provoke hazards.
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 9) < 8, $urandom_range(0, 7), 1'($urandom_range(0, 1)),
            $urandom_range(0, 7), 1'($urandom_range(0, 1)), $urandom_range(0, 7),
            1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0);
      rst = ($urandom_range(0, 99) != 0);
      step();
    end
    rst = 1'b1;
    nops(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errors);
    $finish;
  end

endmodule
